// File: rtl/param_load_pkg.sv
// Shared types for the parameter-load read-side sequencer.
package param_load_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2,
        CHECK = 2'd3
    } state_t;

    function automatic logic [31:0] core_onehot(input logic [31:0] idx);
        core_onehot = 32'd1 << idx;
    endfunction

endpackage

// File: rtl/param_addr_gen.sv
// Address/core counters for the parameter load sequence.
module param_addr_gen #(
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 256,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic          rclk,
    input  logic          rrst_n,
    input  logic          clear,
    input  logic          advance,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] core,
    output logic          last
);

    logic addr_end;
    logic core_end;

    assign addr_end = (addr == AW'(DEPTH - 1));
    assign core_end = (core == CW'(NUM_CORES - 1));
    assign last     = addr_end & core_end;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            addr <= '0;
            core <= '0;
        end else if (clear) begin
            addr <= '0;
            core <= '0;
        end else if (advance) begin
            if (addr_end) begin
                addr <= '0;
                // final wrap returns to core 0 so cur_core reads 0 in DONE
                core <= core_end ? '0 : core + 1'b1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_load_sequencer.sv
// Armed, core-aware FIFO-to-core-memory parameter loader (rclk domain).
// Optional trailing checksum word: define PARAM_LOAD_CHECKSUM_EN.
module param_load_sequencer
    import param_load_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int NUM_CORES = 4,
    parameter int DEPTH     = 256,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 fifo_rempty,
    input  logic [DSIZE-1:0]     fifo_rdata,
    output logic                 fifo_rinc,
    input  logic [NUM_CORES-1:0] core_busy,
    output logic [NUM_CORES-1:0] mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DSIZE-1:0]     mem_data,
    output logic                 busy,
    output logic                 load_done,
    output logic [CW-1:0]        cur_core
`ifdef PARAM_LOAD_CHECKSUM_EN
   ,output logic                 chk_err
`endif
);

    state_t          state;
    logic            pop;
    logic            arm;
    logic            advance;
    logic            clear;
    logic            last;
    logic [AW-1:0]   addr;
    logic [CW-1:0]   core;
`ifdef PARAM_LOAD_CHECKSUM_EN
    logic [DSIZE-1:0] sum;
`endif

    always_comb begin
        pop = 1'b0;
        unique case (state)
            LOAD:    pop = ~fifo_rempty & ~core_busy[core] & ~abort;
`ifdef PARAM_LOAD_CHECKSUM_EN
            CHECK:   pop = ~fifo_rempty & ~abort;
`endif
            default: pop = 1'b0;
        endcase
    end

    assign fifo_rinc = pop;
    assign arm       = start & ~abort & ((state == IDLE) | (state == DONE));
    assign advance   = pop & (state == LOAD);
    assign clear     = abort | arm;
    assign cur_core  = core;

    param_addr_gen #(
        .NUM_CORES (NUM_CORES),
        .DEPTH     (DEPTH)
    ) u_addr_gen (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .clear   (clear),
        .advance (advance),
        .addr    (addr),
        .core    (core),
        .last    (last)
    );

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state     <= IDLE;
            mem_we    <= '0;
            mem_addr  <= '0;
            mem_data  <= '0;
            busy      <= 1'b0;
            load_done <= 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
            sum       <= '0;
            chk_err   <= 1'b0;
`endif
        end else begin
            mem_we <= '0;
            if (abort) begin
                state     <= IDLE;
                busy      <= 1'b0;
                load_done <= 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
                sum       <= '0;
                chk_err   <= 1'b0;
`endif
            end else if (arm) begin
                state     <= LOAD;
                busy      <= 1'b1;
                load_done <= 1'b0;
`ifdef PARAM_LOAD_CHECKSUM_EN
                sum       <= '0;
                chk_err   <= 1'b0;
`endif
            end else begin
                unique case (state)
                    LOAD: begin
                        if (pop) begin
                            mem_we   <= NUM_CORES'(core_onehot(32'(core)));
                            mem_addr <= addr;
                            mem_data <= fifo_rdata;
`ifdef PARAM_LOAD_CHECKSUM_EN
                            sum <= sum + fifo_rdata;
                            if (last) state <= CHECK;
`else
                            if (last) begin
                                state     <= DONE;
                                busy      <= 1'b0;
                                load_done <= 1'b1;
                            end
`endif
                        end
                    end
                    CHECK: begin
`ifdef PARAM_LOAD_CHECKSUM_EN
                        if (pop) begin
                            chk_err   <= (fifo_rdata != sum);
                            state     <= DONE;
                            busy      <= 1'b0;
                            load_done <= 1'b1;
                        end
`else
                        state <= IDLE;
`endif
                    end
                    IDLE:    state <= IDLE;
                    DONE:    state <= DONE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_param_load_sequencer.sv
// Directed bench for param_load_sequencer (NUM_CORES=2, DEPTH=4).
module tb_param_load_sequencer;

    localparam int NC = 2;
    localparam int DP = 4;
    localparam int DW = 8;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          starve = 1'b0;
    logic [NC-1:0] core_busy = '0;
    logic          fifo_rempty;
    logic          fifo_rinc;
    logic [DW-1:0] fifo_rdata;
    logic [NC-1:0] mem_we;
    logic [1:0]    mem_addr;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic          load_done;
    logic          cur_core;
`ifdef PARAM_LOAD_CHECKSUM_EN
    logic          chk_err;
`endif

    logic [7:0] fmem [0:63];
    int rp = 0;
    int wp = 0;
    int pops = 0;
    int n_cmp = 0;
    int n_bad = 0;

    assign fifo_rempty = (rp == wp) || starve;
    assign fifo_rdata  = fmem[rp[5:0]];

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (fifo_rinc) begin
            rp   <= rp + 1;
            pops <= pops + 1;
        end
    end

    param_load_sequencer #(
        .DSIZE     (DW),
        .NUM_CORES (NC),
        .DEPTH     (DP)
    ) dut (
        .rclk        (rclk),
        .rrst_n      (rrst_n),
        .start       (start),
        .abort       (abort),
        .fifo_rempty (fifo_rempty),
        .fifo_rdata  (fifo_rdata),
        .fifo_rinc   (fifo_rinc),
        .core_busy   (core_busy),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .busy        (busy),
        .load_done   (load_done),
        .cur_core    (cur_core)
`ifdef PARAM_LOAD_CHECKSUM_EN
       ,.chk_err     (chk_err)
`endif
    );

    typedef struct {
        logic       st;
        logic       ab;
        logic       sv;
        logic [1:0] cb;
        logic       rinc;
        logic [1:0] we;
        logic [1:0] addr;
        logic [7:0] data;
        logic       done;
        logic       bsy;
        logic       cur;
    } vec_t;

    vec_t vecs [0:36];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic setv(input int i, input logic st, input logic ab,
                        input logic sv, input logic [1:0] cb,
                        input logic rinc, input logic [1:0] we,
                        input logic [1:0] addr, input logic [7:0] data,
                        input logic done, input logic bsy,
                        input logic cur);
        vecs[i] = '{st, ab, sv, cb, rinc, we, addr, data, done, bsy, cur};
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wp[5:0]] = d;
        wp = wp + 1;
    endtask

    task automatic run(input int i);
        start     = vecs[i].st;
        abort     = vecs[i].ab;
        starve    = vecs[i].sv;
        core_busy = vecs[i].cb;
        #1;
        chk($sformatf("v%0d rinc", i), 32'(fifo_rinc), 32'(vecs[i].rinc));
        @(posedge rclk);
        #1;
        chk($sformatf("v%0d we", i), 32'(mem_we), 32'(vecs[i].we));
        if (vecs[i].we != 2'b00) begin
            chk($sformatf("v%0d addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d data", i), 32'(mem_data), 32'(vecs[i].data));
        end
        chk($sformatf("v%0d done", i), 32'(load_done), 32'(vecs[i].done));
        chk($sformatf("v%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
        chk($sformatf("v%0d core", i), 32'(cur_core), 32'(vecs[i].cur));
    endtask

    task automatic run_seg(input int lo, input int hi, input int exp_pops);
        int p0;
        p0 = pops;
        for (int i = lo; i <= hi; i++) run(i);
        start = 0; abort = 0; starve = 0; core_busy = '0;
        chk($sformatf("pops %0d..%0d", lo, hi), 32'(pops - p0), 32'(exp_pops));
    endtask

`ifdef PARAM_LOAD_CHECKSUM_EN
    task automatic chk_run(input logic [7:0] cs, input logic exp_err);
        int wr;
        int p0;
        wr = 0;
        p0 = pops;
        for (int k = 1; k <= 8; k++) push(8'(k));
        push(cs);
        start = 1;
        for (int k = 0; k < 12; k++) begin
            @(posedge rclk);
            #1;
            start = 0;
            if (mem_we != '0) wr++;
        end
        chk("cs done", 32'(load_done), 32'd1);
        chk("cs err", 32'(chk_err), 32'(exp_err));
        chk("cs writes", 32'(wr), 32'd8);
        chk("cs pops", 32'(pops - p0), 32'd9);
        chk("cs busy", 32'(busy), 32'd0);
    endtask
`endif

    initial begin
        //   i  st ab sv cb rinc we addr data done bsy cur
        setv( 0, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        setv( 1, 0, 0, 0, 0, 1, 1, 0, 8'h10, 0, 1, 0);
        setv( 2, 0, 0, 0, 0, 1, 1, 1, 8'h11, 0, 1, 0);
        setv( 3, 0, 0, 0, 0, 1, 1, 2, 8'h12, 0, 1, 0);
        setv( 4, 0, 0, 0, 0, 1, 1, 3, 8'h13, 0, 1, 1);
        setv( 5, 0, 0, 0, 0, 1, 2, 0, 8'h14, 0, 1, 1);
        setv( 6, 0, 0, 0, 0, 1, 2, 1, 8'h15, 0, 1, 1);
        setv( 7, 0, 0, 0, 0, 1, 2, 2, 8'h16, 0, 1, 1);
        setv( 8, 0, 0, 0, 0, 1, 2, 3, 8'h17, 1, 0, 0);
        setv( 9, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0);
        setv(10, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        setv(11, 0, 0, 0, 0, 1, 1, 0, 8'h20, 0, 1, 0);
        setv(12, 0, 0, 0, 0, 1, 1, 1, 8'h21, 0, 1, 0);
        for (int i = 13; i <= 17; i++)
            setv(i, 0, 0, 1, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        setv(18, 0, 0, 0, 0, 1, 1, 2, 8'h22, 0, 1, 0);
        setv(19, 0, 0, 0, 0, 1, 1, 3, 8'h23, 0, 1, 1);
        setv(20, 0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 1, 1);
        setv(21, 0, 0, 0, 2, 0, 0, 0, 8'h00, 0, 1, 1);
        setv(22, 0, 0, 0, 0, 1, 2, 0, 8'h24, 0, 1, 1);
        setv(23, 1, 0, 0, 0, 1, 2, 1, 8'h25, 0, 1, 1);
        setv(24, 0, 0, 0, 1, 1, 2, 2, 8'h26, 0, 1, 1);
        setv(25, 0, 0, 0, 0, 1, 2, 3, 8'h27, 1, 0, 0);
        setv(26, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0);
        setv(27, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        setv(28, 0, 0, 0, 0, 1, 1, 0, 8'h30, 0, 1, 0);
        setv(29, 0, 0, 0, 0, 1, 1, 1, 8'h31, 0, 1, 0);
        setv(30, 0, 0, 0, 0, 1, 1, 2, 8'h32, 0, 1, 0);
        setv(31, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        setv(32, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 0);
        setv(33, 0, 0, 0, 0, 1, 1, 0, 8'h33, 0, 1, 0);
        setv(34, 0, 0, 0, 0, 1, 1, 1, 8'h34, 0, 1, 0);
        setv(35, 1, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        setv(36, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0);

        #3;
        chk("rst we", 32'(mem_we), 32'd0);
        chk("rst addr", 32'(mem_addr), 32'd0);
        chk("rst data", 32'(mem_data), 32'd0);
        chk("rst done", 32'(load_done), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst core", 32'(cur_core), 32'd0);
        chk("rst rinc", 32'(fifo_rinc), 32'd0);
        #9;
        rrst_n = 1'b1;

`ifdef PARAM_LOAD_CHECKSUM_EN
        chk_run(8'h24, 1'b0);
        chk_run(8'h25, 1'b1);
`else
        for (int k = 0; k < 8; k++) push(8'(8'h10 + k));
        run_seg(0, 9, 8);
        for (int k = 0; k < 8; k++) push(8'(8'h20 + k));
        run_seg(10, 26, 8);
        for (int k = 0; k < 8; k++) push(8'(8'h30 + k));
        run_seg(27, 36, 5);
`endif

        for (int k = 0; k < 4; k++) push(8'(8'h40 + k));
        start = 1;
        @(posedge rclk);
        #1;
        start = 0;
        @(posedge rclk);
        #1;
        @(posedge rclk);
        #1;
        chk("pre-rst busy", 32'(busy), 32'd1);
        chk("pre-rst addr", 32'(mem_addr), 32'd1);
        #2;
        rrst_n = 1'b0;
        #1;
        chk("async we", 32'(mem_we), 32'd0);
        chk("async addr", 32'(mem_addr), 32'd0);
        chk("async data", 32'(mem_data), 32'd0);
        chk("async busy", 32'(busy), 32'd0);
        chk("async done", 32'(load_done), 32'd0);
        chk("async core", 32'(cur_core), 32'd0);
        chk("async rinc", 32'(fifo_rinc), 32'd0);
        #3;
        rrst_n = 1'b1;
        @(posedge rclk);
        #1;
        chk("post-rst we", 32'(mem_we), 32'd0);
        chk("post-rst rinc", 32'(fifo_rinc), 32'd0);
        chk("post-rst busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
